// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_pkg
// Description : Shared CSR addresses, default cause codes and FSM state
//               encoding for the trap controller.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

    // Machine-mode CSR addresses touched by the trap sequence
    localparam logic [31:0] CSR_MTVEC  = 32'h0000_0305;
    localparam logic [31:0] CSR_MEPC   = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE = 32'h0000_0342;

    // Default mcause codes (overridable through the top-level parameters)
    localparam logic [31:0] CAUSE_ECALL_DEF   = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK_DEF  = 32'd3;
    localparam logic [31:0] CAUSE_EXT_INT_DEF = 32'h8000_000B;

    // Trap sequencer states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_MEPC   = 3'd1,
        WR_MCAUSE = 3'd2,
        TRAP_JMP  = 3'd3,
        RET_JMP   = 3'd4
    } trap_state_e;

endpackage : trap_ctrl_pkg
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_if
// Description : Pipeline / CSR-file / PC-redirect signals of the trap
//               controller. The controller connects through the slave
//               modport, the surrounding pipeline through the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface trap_ctrl_if;

    // Events and context from the execute stage
    logic        ecall_i;
    logic        ebreak_i;
    logic        mret_i;
    logic        int_flag_i;
    logic [31:0] inst_addr_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        ex_csr_we_i;

    // CSR file port
    logic        csr_we_o;
    logic [31:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic [31:0] csr_raddr_o;
    logic [31:0] csr_rdata_i;

    // Pipeline control
    logic        hold_flag_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    modport slave (
        input  ecall_i, ebreak_i, mret_i, int_flag_i, inst_addr_i,
               jump_flag_i, jump_addr_i, ex_csr_we_i, csr_rdata_i,
        output csr_we_o, csr_waddr_o, csr_wdata_o, csr_raddr_o,
               hold_flag_o, int_assert_o, int_addr_o
    );

    modport master (
        output ecall_i, ebreak_i, mret_i, int_flag_i, inst_addr_i,
               jump_flag_i, jump_addr_i, ex_csr_we_i, csr_rdata_i,
        input  csr_we_o, csr_waddr_o, csr_wdata_o, csr_raddr_o,
               hold_flag_o, int_assert_o, int_addr_o
    );

endinterface : trap_ctrl_if
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Trap/interrupt sequencer. Saves mepc and mcause through the
//               shared CSR write port (yielding to execute-stage writes),
//               then redirects the PC to mtvec; mret redirects to mepc.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] CAUSE_ECALL   = CAUSE_ECALL_DEF,
    parameter logic [31:0] CAUSE_EBREAK  = CAUSE_EBREAK_DEF,
    parameter logic [31:0] CAUSE_EXT_INT = CAUSE_EXT_INT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    trap_ctrl_if.slave       bus
);

    trap_state_e state_q, state_d;
    logic [31:0] epc_q,   epc_d;
    logic [31:0] cause_q, cause_d;

    logic        csr_we;
    logic [31:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_raddr;
    logic        hold_flag;
    logic        int_assert;
    logic [31:0] int_addr;

    // State and trap-context registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            epc_q   <= 32'd0;
            cause_q <= 32'd0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    // Next-state and output decode; everything is forced low while in reset
    always_comb begin
        state_d    = state_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        csr_we     = 1'b0;
        csr_waddr  = 32'd0;
        csr_wdata  = 32'd0;
        csr_raddr  = 32'd0;
        hold_flag  = 1'b0;
        int_assert = 1'b0;
        int_addr   = 32'd0;

        case (state_q)
            IDLE: begin
                // Fixed priority: ecall > ebreak > mret > external interrupt
                if (bus.ecall_i) begin
                    epc_d     = bus.inst_addr_i;
                    cause_d   = CAUSE_ECALL;
                    state_d   = WR_MEPC;
                    hold_flag = 1'b1;
                end else if (bus.ebreak_i) begin
                    epc_d     = bus.inst_addr_i;
                    cause_d   = CAUSE_EBREAK;
                    state_d   = WR_MEPC;
                    hold_flag = 1'b1;
                end else if (bus.mret_i) begin
                    state_d   = RET_JMP;
                    hold_flag = 1'b1;
                end else if (bus.int_flag_i) begin
                    // A redirect in flight means the target is the resume PC
                    epc_d     = bus.jump_flag_i ? bus.jump_addr_i : bus.inst_addr_i;
                    cause_d   = CAUSE_EXT_INT;
                    state_d   = WR_MEPC;
                    hold_flag = 1'b1;
                end
            end
            WR_MEPC: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = epc_q;
                hold_flag = 1'b1;
                // Execute owns the CSR port this cycle: repeat the write
                if (!bus.ex_csr_we_i) state_d = WR_MCAUSE;
            end
            WR_MCAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = cause_q;
                hold_flag = 1'b1;
                if (!bus.ex_csr_we_i) state_d = TRAP_JMP;
            end
            TRAP_JMP: begin
                csr_raddr  = CSR_MTVEC;
                int_addr   = bus.csr_rdata_i;
                int_assert = 1'b1;
                hold_flag  = 1'b1;
                state_d    = IDLE;
            end
            RET_JMP: begin
                csr_raddr  = CSR_MEPC;
                int_addr   = bus.csr_rdata_i;
                int_assert = 1'b1;
                hold_flag  = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!rst) begin
            csr_we     = 1'b0;
            csr_waddr  = 32'd0;
            csr_wdata  = 32'd0;
            csr_raddr  = 32'd0;
            hold_flag  = 1'b0;
            int_assert = 1'b0;
            int_addr   = 32'd0;
        end
    end

    assign bus.csr_we_o     = csr_we;
    assign bus.csr_waddr_o  = csr_waddr;
    assign bus.csr_wdata_o  = csr_wdata;
    assign bus.csr_raddr_o  = csr_raddr;
    assign bus.hold_flag_o  = hold_flag;
    assign bus.int_assert_o = int_assert;
    assign bus.int_addr_o   = int_addr;

endmodule : trap_ctrl
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Self-checking bench for trap_ctrl. A behavioural model walks
//               a list of pending trap actions and owns a small CSR file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam logic [31:0] C_ECALL  = 32'd11;
    localparam logic [31:0] C_EBREAK = 32'd3;
    localparam logic [31:0] C_EXT    = 32'h8000_000B;

    logic clk = 1'b0;
    logic rst;
    trap_ctrl_if bus ();

    trap_ctrl #(
        .CAUSE_ECALL   (C_ECALL),
        .CAUSE_EBREAK  (C_EBREAK),
        .CAUSE_EXT_INT (C_EXT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // CSR file seen by the controller
    logic [31:0] csr_mepc   = 32'd0;
    logic [31:0] csr_mcause = 32'd0;
    logic [31:0] csr_mtvec  = 32'd0;

    always_comb begin
        case (bus.csr_raddr_o)
            CSR_MTVEC:  bus.csr_rdata_i = csr_mtvec;
            CSR_MEPC:   bus.csr_rdata_i = csr_mepc;
            CSR_MCAUSE: bus.csr_rdata_i = csr_mcause;
            default:    bus.csr_rdata_i = 32'd0;
        endcase
    end

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Model: queue of remaining actions for the current trap/return.
    // Action codes: 1 = write mepc, 2 = write mcause, 3 = jump to mtvec,
    // 4 = jump to mepc. Empty queue means the controller is free.
    int          act_q[$];
    logic [31:0] m_epc   = 32'd0;
    logic [31:0] m_cause = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs after the falling edge, check outputs
    // against the model, then advance the model across the rising edge.
    task automatic cyc(input logic r, input logic e, input logic b, input logic m,
                       input logic it, input logic jf, input logic [31:0] pc,
                       input logic [31:0] ja, input logic ex);
        logic        x_hold, x_we, x_as;
        logic [31:0] x_wa, x_wd, x_ra, x_ia;
        logic        do_pop;
        @(negedge clk);
        rst = r;
        bus.ecall_i = e;  bus.ebreak_i = b;   bus.mret_i = m;
        bus.int_flag_i = it; bus.jump_flag_i = jf;
        bus.inst_addr_i = pc; bus.jump_addr_i = ja; bus.ex_csr_we_i = ex;
        #1;
        x_hold = 1'b0; x_we = 1'b0; x_as = 1'b0;
        x_wa = 32'd0; x_wd = 32'd0; x_ra = 32'd0; x_ia = 32'd0;
        do_pop = 1'b0;
        if (!r) begin
            act_q.delete();
            m_epc = 32'd0; m_cause = 32'd0;
        end else if (act_q.size() == 0) begin
            if (e || b || it) begin
                x_hold  = 1'b1;
                m_epc   = (e || b) ? pc : (jf ? ja : pc);
                m_cause = e ? C_ECALL : (b ? C_EBREAK : C_EXT);
                if (!e && !b && m) begin
                    act_q = '{4};
                end else begin
                    act_q = '{1, 2, 3};
                end
            end else if (m) begin
                x_hold = 1'b1;
                act_q  = '{4};
            end
        end else begin
            x_hold = 1'b1;
            case (act_q[0])
                1: begin x_we = 1'b1; x_wa = CSR_MEPC;   x_wd = m_epc;   do_pop = !ex; end
                2: begin x_we = 1'b1; x_wa = CSR_MCAUSE; x_wd = m_cause; do_pop = !ex; end
                3: begin x_ra = CSR_MTVEC; x_as = 1'b1; x_ia = csr_mtvec; do_pop = 1'b1; end
                default: begin x_ra = CSR_MEPC; x_as = 1'b1; x_ia = csr_mepc; do_pop = 1'b1; end
            endcase
        end
        chk("hold_flag",  {31'd0, bus.hold_flag_o},  {31'd0, x_hold});
        chk("csr_we",     {31'd0, bus.csr_we_o},     {31'd0, x_we});
        chk("csr_waddr",  bus.csr_waddr_o,           x_wa);
        chk("csr_wdata",  bus.csr_wdata_o,           x_wd);
        chk("csr_raddr",  bus.csr_raddr_o,           x_ra);
        chk("int_assert", {31'd0, bus.int_assert_o}, {31'd0, x_as});
        chk("int_addr",   bus.int_addr_o,            x_ia);
        @(posedge clk);
        // Execute-stage writes win the CSR port; trap writes land otherwise
        if (x_we && !ex) begin
            if (x_wa == CSR_MEPC)   csr_mepc   = x_wd;
            if (x_wa == CSR_MCAUSE) csr_mcause = x_wd;
        end
        if (do_pop) void'(act_q.pop_front());
    endtask

    task automatic idle_cyc();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        bus.ecall_i = 1'b0; bus.ebreak_i = 1'b0; bus.mret_i = 1'b0;
        bus.int_flag_i = 1'b0; bus.jump_flag_i = 1'b0;
        bus.inst_addr_i = 32'd0; bus.jump_addr_i = 32'd0; bus.ex_csr_we_i = 1'b0;

        // Reset state: every output low even with all events raised
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h20, 1'b1);
        idle_cyc();

        // ecall at 0x100, mtvec 0x200: redirect on the third cycle after the event
        csr_mtvec = 32'h200;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd0, 1'b0);
        repeat (3) idle_cyc();
        chk("ecall_mepc",   csr_mepc,   32'h100);
        chk("ecall_mcause", csr_mcause, 32'd11);

        // Interrupt while execute redirects: epc is the redirect target
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h120, 32'h340, 1'b0);
        repeat (3) idle_cyc();
        chk("int_mepc",   csr_mepc,   32'h340);
        chk("int_mcause", csr_mcause, 32'h8000_000B);

        // ebreak with two retry cycles in WR_MEPC: redirect on cycle 5
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        repeat (3) idle_cyc();
        chk("ebreak_mepc",   csr_mepc,   32'h400);
        chk("ebreak_mcause", csr_mcause, 32'd3);

        // mret with mepc 0x104
        csr_mepc = 32'h104;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        idle_cyc();
        idle_cyc();

        // ecall and interrupt together: ecall first, interrupt after return
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 32'd0, 1'b0);
        chk("prio_mcause", csr_mcause, 32'd11);
        repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h504, 32'd0, 1'b0);
        chk("prio_int_mcause", csr_mcause, 32'h8000_000B);
        chk("prio_int_mepc",   csr_mepc,   32'h504);

        // Reset during WR_MCAUSE: abandon, no mcause write, no redirect
        csr_mcause = 32'h55;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600, 32'd0, 1'b0);
        idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) idle_cyc();
        chk("rst_mcause_kept", csr_mcause, 32'h55);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 31) == 0) csr_mtvec = $urandom & 32'hFFFF_FFFC;
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 1) == 0),
                $urandom & 32'hFFFF_FFFC,
                $urandom & 32'hFFFF_FFFC,
                ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_trap_ctrl
`default_nettype wire
